mux_key_table: RTL and testbench

Programmable, registered key-to-data lookup mux with per-entry valid bits, priority matching, miss default and a valid/ready output stage. It generalises the fixed-key combinational selector: keys are no longer implied by input position but stored in a writable table. Hit/miss statistics are kept on chip. It sits between decode logic and datapath selects wherever the key set must change at run time or a registered, back-pressurable select is required.

---
 rtl/mux_key_table.sv | 136 +++++++++++++
 tb/tb_mux_key_table.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_table.sv
// Programmable key->data lookup table with priority match, miss default and saturating hit/miss counters.
// Latency 1 cycle through one output register; in_ready = !out_valid || out_ready, so no bubbles and the result holds under stall.
module mux_key_table #(
  parameter  int NR_KEY   = 4,
  parameter  int KEY_LEN  = 4,
  parameter  int DATA_LEN = 8,
  parameter  int CNT_LEN  = 16,
  localparam int IDX_LEN  = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic [DATA_LEN-1:0] def_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_LEN-1:0]  out_idx,
  output logic [CNT_LEN-1:0]  hit_cnt,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  logic [NR_KEY-1:0]   vld_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q,  out_data_d;
  logic                out_hit_q,   out_hit_d;
  logic [IDX_LEN-1:0]  out_idx_q,   out_idx_d;
  logic [CNT_LEN-1:0]  hit_cnt_q,   hit_cnt_d;
  logic [CNT_LEN-1:0]  miss_cnt_q,  miss_cnt_d;

  logic                match_hit;
  logic [IDX_LEN-1:0]  match_idx;
  logic [DATA_LEN-1:0] match_data;
  logic                accept;

  // Out-of-range wr_idx never equals any loop index, so it is dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (clr) begin
          vld_q[i] <= 1'b0;
        end else if (wr_en && wr_idx == IDX_LEN'(i)) begin
          vld_q[i]  <= wr_vld;
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    match_data = def_data;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (vld_q[i] && key_q[i] == in_key) begin
        match_hit  = 1'b1;
        match_idx  = IDX_LEN'(i);
        match_data = data_q[i];
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = match_data;
      out_hit_d   = match_hit;
      out_idx_d   = match_idx;
      if (match_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Directed bench for mux_key_table; a second instance with 2-bit counters shares the stimulus.
module tb_mux_key_table;

  logic       clk = 1'b0;
  logic       rst, clr, wr_en, wr_vld, in_valid, out_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_key, in_key;
  logic [7:0] wr_data, def_data;

  logic        in_ready, out_valid, out_hit;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic [15:0] hit_cnt, miss_cnt;

  logic       in_ready2, out_valid2, out_hit2;
  logic [7:0] out_data2;
  logic [1:0] out_idx2;
  logic [1:0] hit_cnt2, miss_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_key_table dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_vld(wr_vld), .def_data(def_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hit(out_hit), .out_idx(out_idx), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  mux_key_table #(.CNT_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_vld(wr_vld), .def_data(def_data), .in_valid(in_valid),
    .in_ready(in_ready2), .in_key(in_key), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_hit(out_hit2), .out_idx(out_idx2), .hit_cnt(hit_cnt2),
    .miss_cnt(miss_cnt2)
  );

  // Called just after a falling edge; the write lands on the following rising edge.
  task automatic do_write(input logic [1:0] idx, input logic [3:0] k,
                          input logic [7:0] d, input logic v);
    wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d; wr_vld = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== 12'h000) begin errors++;
      $display("FAIL reset_out: got %h expected 000", {out_valid, out_hit, out_idx, out_data}); end
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin errors++;
      $display("FAIL reset_cnt: got %h expected 0", {hit_cnt, miss_cnt}); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_key = 4'd3; def_data = 8'hAA;
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b0, 2'd0, 8'hAA}) begin errors++;
      $display("FAIL first_miss: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b0, 2'd0, 8'hAA}); end
    checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin errors++;
      $display("FAIL first_miss_cnt: got miss=%0d hit=%0d expected miss=1 hit=0", miss_cnt, hit_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_hit;
    in_valid = 1'b1; in_key = 4'd5; def_data = 8'h55;
    do_write(2'd2, 4'd5, 8'h3C, 1'b1);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b0, 2'd0, 8'h55}) begin errors++;
      $display("FAIL same_cycle_write: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b0, 2'd0, 8'h55}); end
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b1, 2'd2, 8'h3C}) begin errors++;
      $display("FAIL write_then_hit: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b1, 2'd2, 8'h3C}); end
    checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd2) begin errors++;
      $display("FAIL write_hit_cnt: got hit=%0d miss=%0d expected hit=1 miss=2", hit_cnt, miss_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority;
    do_write(2'd1, 4'd7, 8'h11, 1'b1);
    do_write(2'd3, 4'd7, 8'h33, 1'b1);
    in_valid = 1'b1; in_key = 4'd7; def_data = 8'h00;
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b1, 2'd1, 8'h11}) begin errors++;
      $display("FAIL priority_low: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b1, 2'd1, 8'h11}); end
    in_valid = 1'b0;
    do_write(2'd1, 4'd7, 8'h11, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b1, 2'd3, 8'h33}) begin errors++;
      $display("FAIL priority_delete: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b1, 2'd3, 8'h33}); end
    checks++; if (hit_cnt !== 16'd3) begin errors++;
      $display("FAIL priority_cnt: got %0d expected 3", hit_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_write(2'd0, 4'd1, 8'hA1, 1'b1);
    in_valid = 1'b1; in_key = 4'd1; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ready_idle: got %b expected 1", in_ready); end
    @(negedge clk);
    in_key = 4'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({in_ready, out_valid, out_hit, out_idx, out_data} !== {1'b0, 1'b1, 1'b1, 2'd0, 8'hA1}) begin errors++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, {in_ready, out_valid, out_hit, out_idx, out_data}, {1'b0, 1'b1, 1'b1, 2'd0, 8'hA1}); end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if ({out_valid, out_idx, out_data} !== {1'b1, 2'd2, 8'h3C}) begin errors++;
      $display("FAIL bp_second: got %h expected %h", {out_valid, out_idx, out_data}, {1'b1, 2'd2, 8'h3C}); end
    in_key = 4'd7;
    @(negedge clk);
    checks++; if ({out_valid, out_idx, out_data} !== {1'b1, 2'd3, 8'h33}) begin errors++;
      $display("FAIL bp_third: got %h expected %h", {out_valid, out_idx, out_data}, {1'b1, 2'd3, 8'h33}); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drain: got %b expected 0", out_valid); end
    checks++; if (hit_cnt !== 16'd6 || miss_cnt !== 16'd2) begin errors++;
      $display("FAIL bp_cnt: got hit=%0d miss=%0d expected hit=6 miss=2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_saturate_clr;
    rst = 1'b1; #2; rst = 1'b0;
    in_valid = 1'b1; in_key = 4'd9; def_data = 8'h00;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (miss_cnt !== 16'd5 || miss_cnt2 !== 2'd3 || hit_cnt2 !== 2'd0) begin errors++;
      $display("FAIL sat_miss: got miss=%0d miss2=%0d hit2=%0d expected 5 3 0", miss_cnt, miss_cnt2, hit_cnt2); end
    do_write(2'd0, 4'd2, 8'h42, 1'b1);
    in_valid = 1'b1; in_key = 4'd2; clr = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid2, out_hit2, out_idx2, out_data2} !== {1'b1, 1'b1, 2'd0, 8'h42}) begin errors++;
      $display("FAIL clr_lookup: got %h expected %h", {out_valid2, out_hit2, out_idx2, out_data2}, {1'b1, 1'b1, 2'd0, 8'h42}); end
    checks++; if ({hit_cnt, miss_cnt, hit_cnt2, miss_cnt2} !== 36'h0) begin errors++;
      $display("FAIL clr_cnt: got %h expected 0", {hit_cnt, miss_cnt, hit_cnt2, miss_cnt2}); end
    #1;
    checks++; if (in_ready2 !== 1'b0) begin errors++;
      $display("FAIL clr_stall: got %b expected 0", in_ready2); end
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_data} !== {1'b1, 1'b1, 8'h42}) begin errors++;
      $display("FAIL clr_pending: got %h expected %h", {out_valid, out_hit, out_data}, {1'b1, 1'b1, 8'h42}); end
    in_valid = 1'b1; in_key = 4'd2; def_data = 8'h77; out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid2, out_hit2, out_idx2, out_data2} !== {1'b1, 1'b0, 2'd0, 8'h77}) begin errors++;
      $display("FAIL clr_table: got %h expected %h", {out_valid2, out_hit2, out_idx2, out_data2}, {1'b1, 1'b0, 2'd0, 8'h77}); end
    checks++; if (miss_cnt2 !== 2'd1 || hit_cnt2 !== 2'd0) begin errors++;
      $display("FAIL clr_recount: got miss2=%0d hit2=%0d expected 1 0", miss_cnt2, hit_cnt2); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    do_write(2'd0, 4'd2, 8'h42, 1'b1);
    in_valid = 1'b1; in_key = 4'd2; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_hit, out_data} !== {1'b1, 1'b1, 8'h42} || hit_cnt !== 16'd1) begin errors++;
      $display("FAIL arst_pre: got %h hit=%0d expected %h hit=1", {out_valid, out_hit, out_data}, hit_cnt, {1'b1, 1'b1, 8'h42}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== 12'h000) begin errors++;
      $display("FAIL arst_out: got %h expected 000", {out_valid, out_hit, out_idx, out_data}); end
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL arst_cnt: got cnt=%h ready=%b expected 0 1", {hit_cnt, miss_cnt}, in_ready); end
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_key = 4'd2; def_data = 8'h66;
    @(negedge clk);
    checks++; if ({out_valid, out_hit, out_idx, out_data} !== {1'b1, 1'b0, 2'd0, 8'h66}) begin errors++;
      $display("FAIL arst_table: got %h expected %h", {out_valid, out_hit, out_idx, out_data}, {1'b1, 1'b0, 2'd0, 8'h66}); end
    checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin errors++;
      $display("FAIL arst_recount: got miss=%0d hit=%0d expected 1 0", miss_cnt, hit_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_vld = 1'b0; wr_idx = '0; wr_key = '0;
    wr_data = '0; def_data = '0; in_valid = 1'b0; in_key = '0; out_ready = 1'b1;
    test_reset;
    test_write_hit;
    test_priority;
    test_back_to_back;
    test_saturate_clr;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
